// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the space-invaders datapath: fleet state
// encoding, alien-slot geometry, fire-interval floor, game modes and screen edges.
// Latency: n/a (package). Backpressure: n/a.
package space_invaders_pkg;

    // Alien slots on the packed shoot-timer bus and bits per slot.
    localparam int NUM_ALIENS = 12;
    localparam int TIMER_W    = 12;

    // Shortest fire interval, in frames.
    localparam logic [TIMER_W-1:0] MIN_SHOOT = 12'd120;

    // Fleet state encoding.
    localparam logic [2:0] FLEET_IDLE   = 3'd0;
    localparam logic [2:0] FLEET_LOAD   = 3'd1;
    localparam logic [2:0] FLEET_RIGHT  = 3'd2;
    localparam logic [2:0] FLEET_DOWN_R = 3'd3;
    localparam logic [2:0] FLEET_LEFT   = 3'd4;
    localparam logic [2:0] FLEET_DOWN_L = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = FLEET_IDLE,
        ST_LOAD   = FLEET_LOAD,
        ST_RIGHT  = FLEET_RIGHT,
        ST_DOWN_R = FLEET_DOWN_R,
        ST_LEFT   = FLEET_LEFT,
        ST_DOWN_L = FLEET_DOWN_L
    } fleet_state_e;

    // Game modes: 0/1 not playing, 2 playing, 3 frozen.
    localparam logic [1:0] MODE_PLAY   = 2'd2;
    localparam logic [1:0] MODE_FROZEN = 2'd3;

    // Screen-edge constants shared with the aliens block.
    localparam logic [9:0] SCREEN_LEFT_EDGE  = 10'd16;
    localparam logic [9:0] SCREEN_RIGHT_EDGE = 10'd624;
    localparam logic [9:0] SCREEN_BOTTOM     = 10'd400;

endpackage

// File: rtl/fleet_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), free-running on every clk.
// Latency: new value each clk. Backpressure: none, never stalls.
// Ports: clk, rst (async active-high, loads SEED), lfsr (current register value).
module fleet_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    // Taps 16,14,13,11 map to bits 15,13,12,10. The all-zero guard only
    // matters if the register were ever corrupted; a maximal LFSR started
    // from a non-zero seed never reaches zero on its own.
    assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]
                  ^ (lfsr_q == 16'h0000);
    assign lfsr_d = {lfsr_q[14:0], fb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/alien_fleet_controller.sv
// Fleet march scheduler (right/down/left/down) and per-alien fire-interval loader.
// Latency: frame tick 1 clk after frame start; moves are Moore, 1 clk after the decision.
// Backpressure: none; mode 3 freezes march state and slots, LFSR keeps running.
// Ports: clk, rst (async active-high); mode, xCoord, yCoord, edge_any in;
// move_left/right/down, shoot_timer (slot i at [12i+11:12i]), drop_count out.
module alien_fleet_controller #(
    parameter int                   NUM_ALIENS   = space_invaders_pkg::NUM_ALIENS,
    parameter int                   TIMER_W      = space_invaders_pkg::TIMER_W,
    parameter logic [TIMER_W-1:0]   MIN_SHOOT    = space_invaders_pkg::MIN_SHOOT,
    parameter logic [8:0]           DOWN_TIMEOUT = 9'd210,
    parameter logic [15:0]          LFSR_SEED    = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [9:0]                    xCoord,
    input  logic [9:0]                    yCoord,
    input  logic                          edge_any,
    output logic                          move_left,
    output logic                          move_right,
    output logic                          move_down,
    output logic [NUM_ALIENS*TIMER_W-1:0] shoot_timer,
    output logic [3:0]                    drop_count
);

    import space_invaders_pkg::*;

    localparam logic [3:0] LAST_SLOT = 4'(NUM_ALIENS - 1);

    fleet_state_e state_q, state_d;

    logic         frame_cond;
    logic         frame_cond_q;
    logic         frame_tick_q;

    logic [3:0]   load_idx_q, load_idx_d;
    logic [3:0]   refresh_idx_q, refresh_idx_d;
    logic [8:0]   down_cnt_q, down_cnt_d;
    logic [8:0]   down_cnt_inc;
    logic [3:0]   drop_cnt_q, drop_cnt_d;

    logic [TIMER_W-1:0] slot_q [NUM_ALIENS];
    logic               slot_we;
    logic [3:0]         slot_widx;
    logic [TIMER_W-1:0] slot_val;
    logic               down_entry;

    logic [15:0]  lfsr_w;
    logic         unused_lfsr_hi;

    fleet_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr_w)
    );

    // Only the low nine bits feed the interval; the rest just keep the sequence long.
    assign unused_lfsr_hi = ^lfsr_w[15:9];
    assign slot_val       = MIN_SHOOT + TIMER_W'(lfsr_w[8:0]);

    assign frame_cond = (xCoord == 10'd0) && (yCoord == 10'd0);

    // The down counter stops at all-ones instead of wrapping.
    assign down_cnt_inc = (down_cnt_q == 9'h1FF) ? down_cnt_q : down_cnt_q + 9'd1;

    always_comb begin
        state_d       = state_q;
        load_idx_d    = load_idx_q;
        refresh_idx_d = refresh_idx_q;
        down_cnt_d    = down_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        slot_we       = 1'b0;
        slot_widx     = load_idx_q;
        down_entry    = 1'b0;

        if (mode == MODE_PLAY) begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_LOAD;
                    load_idx_d = 4'd0;
                end
                // One slot per clk, independent of frame timing.
                ST_LOAD: begin
                    slot_we   = 1'b1;
                    slot_widx = load_idx_q;
                    if (load_idx_q == LAST_SLOT) begin
                        state_d    = ST_RIGHT;
                        load_idx_d = 4'd0;
                    end else begin
                        load_idx_d = load_idx_q + 4'd1;
                    end
                end
                ST_RIGHT: begin
                    if (frame_tick_q && edge_any) begin
                        state_d    = ST_DOWN_R;
                        down_entry = 1'b1;
                    end
                end
                ST_DOWN_R: begin
                    if (frame_tick_q) begin
                        down_cnt_d = down_cnt_inc;
                        if (!edge_any || (down_cnt_inc >= DOWN_TIMEOUT)) begin
                            state_d = ST_LEFT;
                        end
                    end
                end
                ST_LEFT: begin
                    if (frame_tick_q && edge_any) begin
                        state_d    = ST_DOWN_L;
                        down_entry = 1'b1;
                    end
                end
                ST_DOWN_L: begin
                    if (frame_tick_q) begin
                        down_cnt_d = down_cnt_inc;
                        if (!edge_any || (down_cnt_inc >= DOWN_TIMEOUT)) begin
                            state_d = ST_RIGHT;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Entering a drop reloads exactly one slot and advances the refresh pointer.
            if (down_entry) begin
                slot_we       = 1'b1;
                slot_widx     = refresh_idx_q;
                refresh_idx_d = (refresh_idx_q == LAST_SLOT) ? 4'd0 : refresh_idx_q + 4'd1;
                down_cnt_d    = 9'd0;
                drop_cnt_d    = (drop_cnt_q == 4'hF) ? drop_cnt_q : drop_cnt_q + 4'd1;
            end
        end else if (mode != MODE_FROZEN) begin
            // Not playing: abandon the march immediately, even mid-drop.
            state_d       = ST_IDLE;
            load_idx_d    = 4'd0;
            refresh_idx_d = 4'd0;
            down_cnt_d    = 9'd0;
            drop_cnt_d    = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            frame_cond_q  <= 1'b0;
            frame_tick_q  <= 1'b0;
            load_idx_q    <= 4'd0;
            refresh_idx_q <= 4'd0;
            down_cnt_q    <= 9'd0;
            drop_cnt_q    <= 4'd0;
            for (int i = 0; i < NUM_ALIENS; i++) begin
                slot_q[i] <= MIN_SHOOT;
            end
        end else begin
            state_q       <= state_d;
            frame_cond_q  <= frame_cond;
            // Rising-edge detect: one pulse per frame however long (0,0) persists.
            frame_tick_q  <= frame_cond & ~frame_cond_q;
            load_idx_q    <= load_idx_d;
            refresh_idx_q <= refresh_idx_d;
            down_cnt_q    <= down_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            if (slot_we) begin
                slot_q[slot_widx] <= slot_val;
            end
        end
    end

    always_comb begin
        shoot_timer = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            shoot_timer[i*TIMER_W +: TIMER_W] = slot_q[i];
        end
    end

    assign move_right = (state_q == ST_RIGHT);
    assign move_left  = (state_q == ST_LEFT);
    assign move_down  = (state_q == ST_DOWN_R) || (state_q == ST_DOWN_L);
    assign drop_count = drop_cnt_q;

endmodule

// File: doc/alien_fleet_controller.md
# alien_fleet_controller

Fleet-level movement and fire scheduler for the aliens. Sits directly upstream of every `aliens` instance and drives their shared `move_left` / `move_right` / `move_down` controls and the packed 144-bit `shoot_timer` bus. Consumes the OR of all live aliens' `is_edge` outputs and runs the right → down → left → down march, plus a pseudo-random per-alien fire interval.

## Interface
Parameters:
- `NUM_ALIENS`, 12: alien slots on the `shoot_timer` bus.
- `TIMER_W`, 12: bits per shoot-timer slot; `NUM_ALIENS*TIMER_W` must equal 144.
- `MIN_SHOOT`, 12'd120: minimum fire interval, in frames.
- `DOWN_TIMEOUT`, 9'd210: frames spent in a DOWN state before it is forced to exit.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk`, input, 1: pixel clock, the same clock the `aliens` instances use.
- `rst`, input, 1: asynchronous, active-high reset.
- `mode`, input, 2: game mode.
  - 0 or 1: not playing.
  - 2: playing.
  - 3: frozen.
- `xCoord`, input, 10: current pixel x.
- `yCoord`, input, 10: current pixel y.
- `edge_any`, input, 1: OR of the `is_edge` outputs of all live aliens.
- `move_left`, output, 1: fleet moves left.
- `move_right`, output, 1: fleet moves right.
- `move_down`, output, 1: fleet moves down.
- `shoot_timer`, output, 144: slot i occupies bits [12i+11 : 12i], in frames.
- `drop_count`, output, 4: number of fleet drops this game, saturating at 15.

## Operation
Frame tick:
- `frame_tick` is a one-cycle pulse on the rising edge of (`xCoord==0 && yCoord==0`).
- It is registered-edge detected, so it pulses once per frame however long the condition holds.

States: IDLE, LOAD, RIGHT, DOWN_R, LEFT, DOWN_L. Transitions, in priority order:
- Any state → IDLE when `mode` is 0 or 1. This is evaluated every cycle, mid-march included.
- `mode==3` freezes the state, the counters and `shoot_timer`. The LFSR keeps running.
- IDLE → LOAD when `mode==2`.
- LOAD writes one slot per clk, slots 0 to 11, then goes to RIGHT. It does not wait for a frame tick.
- The remaining transitions are evaluated only on a `frame_tick` with `mode==2`:
  - RIGHT → DOWN_R when `edge_any`.
  - DOWN_R → LEFT when `!edge_any` or the down counter reaches `DOWN_TIMEOUT`.
  - LEFT → DOWN_L when `edge_any`.
  - DOWN_L → RIGHT when `!edge_any` or the down counter reaches `DOWN_TIMEOUT`.

Outputs are Moore, decoded from registered state:
- RIGHT: `move_right=1`.
- LEFT: `move_left=1`.
- DOWN_R and DOWN_L: `move_down=1`.
- IDLE and LOAD: all move outputs 0.
- At most one move output is high at any time.

Down counter:
- 9 bits, cleared on entry to DOWN_R or DOWN_L.
- Increments once per `frame_tick` while in a DOWN state; does not wrap.

Fire intervals:
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts every clk, is reset only by `rst`, and is never zero.
- Slot value = `MIN_SHOOT` + zero-extended `lfsr[8:0]`, giving the range 120..631.
- On every entry to DOWN_R or DOWN_L, slot `refresh_idx` is reloaded and `refresh_idx` then increments modulo `NUM_ALIENS`.
- `refresh_idx` is cleared in IDLE.

Drop count:
- `drop_count` increments on each DOWN entry and saturates at 15.
- It is cleared in IDLE.

## Timing
Reset values:
- State: IDLE.
- All move outputs: 0.
- Every `shoot_timer` slot: `MIN_SHOOT`.
- `drop_count`: 0.
- `refresh_idx`: 0.
- Down counter: 0.
- LFSR: `LFSR_SEED`.

Latencies:
- `frame_tick` asserts 1 clk after the frame condition rises.
- A state change occurs in the same clk as `frame_tick`; the move outputs reflect it on the next clk edge.
- LOAD lasts exactly `NUM_ALIENS` clks. The RIGHT state, and `move_right=1`, is reached 13 clks after the first `mode==2` cycle.
- In a DOWN state, an `edge_any` that is still high keeps the state. The aliens clear `is_edge` on their down step, about 200 frames later. `DOWN_TIMEOUT` bounds a stuck `is_edge`.

Simultaneous events:
- `mode` leaving 2 in the same cycle as `frame_tick`: IDLE wins.
- A DOWN entry and a refresh reload are the same event; only one slot is written per entry.
- Async `rst` mid-LOAD: all slots return to `MIN_SHOOT`.

## Structure
- Shared package `space_invaders_pkg` holds:
  - the fleet state encoding (3-bit localparams);
  - `NUM_ALIENS`, `TIMER_W`, `MIN_SHOOT`;
  - the screen-edge constants already used by `aliens`.
- Sub-module `fleet_lfsr`: 16-bit LFSR with `clk`, `rst`, and a `lfsr` output. Instantiated once.

## Test plan
- Reset, then `mode=2` → after 13 clks: `move_right=1`; slots 0..11 hold values in 120..631; `drop_count=0`.
- In RIGHT, assert `edge_any` and give one `frame_tick` → `move_down=1` the next clk; `drop_count=1`; slot 0 reloaded; `refresh_idx=1`.
- In DOWN_R, drop `edge_any` and give a tick → LEFT with `move_left=1`. Then edge, tick, release, tick → RIGHT; `drop_count=2`.
- Hold `edge_any=1` in DOWN_L → exit to RIGHT on the 210th frame tick.
- `mode` 2→3 mid-RIGHT → outputs and slots held while the LFSR advances. Then `mode=0` → IDLE, move outputs 0, `drop_count=0`.
- 16 drops → `drop_count` saturates at 15; `refresh_idx` wraps 11→0.
- Frame condition held high for 5 clks → exactly one `frame_tick`.
